// File: rtl/seq_det_prog_if.sv
// Serial pattern detector bus: serial data, pattern load, counter control,
// and detector outputs. The master side drives the data/control signals and
// observes the outputs.
interface seq_det_prog_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             in;
   logic             in_valid;
   logic [WIDTH-1:0] pattern;
   logic             load;
   logic             overlap;
   logic             clr_cnt;
   logic             z;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   modport master (
      output in, in_valid, pattern, load, overlap, clr_cnt,
      input  z, match_cnt, cnt_sat
   );

   modport slave (
      input  in, in_valid, pattern, load, overlap, clr_cnt,
      output z, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector. Compares the last WIDTH valid bits
// against a loadable pattern and emits a one-cycle registered pulse per
// match, with overlapping or non-overlapping detection and a saturating
// match counter with a sticky saturation flag.
module seq_det_prog #(
   parameter int               WIDTH   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [WIDTH-1:0] RST_PAT = WIDTH'(4'b1001)
) (
   input logic          clk,
   input logic          rst,
   seq_det_prog_if.slave bus
);

   // fill counts 0..WIDTH, so it needs enough bits to hold WIDTH itself
   localparam int               FILL_W   = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
   localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [WIDTH-1:0]  r_pat;
   logic [WIDTH-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic              r_z;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sat;

   logic [WIDTH-1:0]  w_next_hist;
   logic              w_bit_take;
   logic              w_match;

   // load takes precedence over a data bit on the same edge, so a bit
   // presented together with load is dropped and never evaluated
   assign w_bit_take  = bus.in_valid && !bus.load;
   assign w_next_hist = {r_hist[WIDTH-2:0], bus.in};
   assign w_match     = w_bit_take && (w_next_hist == r_pat) && (r_fill >= FILL_THR);

   // pattern, history and fill tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pat  <= RST_PAT;
         r_hist <= '0;
         r_fill <= '0;
      end else if (bus.load) begin
         r_pat  <= bus.pattern;
         r_hist <= '0;
         r_fill <= '0;
      end else if (bus.in_valid) begin
         r_hist <= w_next_hist;
         // non-overlapping mode forgets all bits that contributed to a match
         if (w_match && !bus.overlap) begin
            r_fill <= '0;
         end else if (r_fill != FILL_MAX) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   // registered match pulse, one cycle after the final pattern bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_z <= 1'b0;
      end else begin
         r_z <= w_match;
      end
   end

   // saturating match counter; clear beats a coincident increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (bus.clr_cnt) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (w_match) begin
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         // flag is raised as the counter lands on all-ones and then sticks
         if (r_cnt >= CNT_MAX - 1'b1) begin
            r_sat <= 1'b1;
         end
      end
   end

   assign bus.z         = r_z;
   assign bus.match_cnt = r_cnt;
   assign bus.cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed stimulus with hand-computed match pulses,
// expected outputs queued by the driver and checked by an independent monitor.
module tb_seq_det_prog;

   logic clk;
   logic rst;

   seq_det_prog_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
   seq_det_prog_if #(.WIDTH(4), .CNT_W(2)) bus1 ();

   seq_det_prog #(.WIDTH(4), .CNT_W(8), .RST_PAT(4'b1001)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   seq_det_prog #(.WIDTH(4), .CNT_W(2), .RST_PAT(4'b1001)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int    n_vec = 0;
   int    n_err = 0;

   int    q_sel[$];
   logic  q_z[$];
   int    q_cnt[$];
   logic  q_sat[$];
   string q_tag[$];

   int    e_cnt [2];
   logic  e_sat [2];

   // hand-entered stream and the z pulses it must produce (1 = pulse after that bit)
   int s_a    [21] = '{0,1,0,0,1,0,0,1,1,0,1,0,0,1,0,1,0,0,1,0,1};
   int z_ovl  [21] = '{0,0,0,0,1,0,0,1,0,0,0,0,0,1,0,0,0,0,1,0,0};
   int z_novl [21] = '{0,0,0,0,1,0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,0};
   int s_c    [7]  = '{1,1,0,1,1,0,1};
   int z_c    [7]  = '{0,0,0,1,0,0,1};
   int s_d    [7]  = '{0,0,1,0,0,0,1};
   int z_d    [7]  = '{0,0,0,0,0,0,1};
   int s_e    [16] = '{1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1};
   int z_e    [16] = '{0,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1};

   task automatic idle_all();
      bus0.in = 1'b0; bus0.in_valid = 1'b0; bus0.load = 1'b0; bus0.clr_cnt = 1'b0;
      bus1.in = 1'b0; bus1.in_valid = 1'b0; bus1.load = 1'b0; bus1.clr_cnt = 1'b0;
   endtask

   // drive one cycle of stimulus and queue the outputs expected after its edge
   task automatic step(input int sel, input logic b, input logic v, input logic ld,
                       input logic [3:0] p, input logic ov, input logic clr,
                       input logic ez, input string tag);
      int cmax;
      @(negedge clk);
      idle_all();
      if (sel == 0) begin
         bus0.in = b; bus0.in_valid = v; bus0.load = ld; bus0.pattern = p;
         bus0.overlap = ov; bus0.clr_cnt = clr;
      end else begin
         bus1.in = b; bus1.in_valid = v; bus1.load = ld; bus1.pattern = p;
         bus1.overlap = ov; bus1.clr_cnt = clr;
      end
      cmax = (sel == 0) ? 255 : 3;
      if (clr) begin
         e_cnt[sel] = 0;
         e_sat[sel] = 1'b0;
      end else if (ez) begin
         if (e_cnt[sel] != cmax) e_cnt[sel] = e_cnt[sel] + 1;
         if (e_cnt[sel] == cmax) e_sat[sel] = 1'b1;
      end
      q_sel.push_back(sel);
      q_z.push_back(ez);
      q_cnt.push_back(e_cnt[sel]);
      q_sat.push_back(e_sat[sel]);
      q_tag.push_back(tag);
   endtask

   task automatic check_now(input string tag, input logic az, input int ac, input logic as_,
                            input logic ez, input int ec, input logic es);
      n_vec++;
      if (az !== ez || ac != ec || as_ !== es) begin
         n_err++;
         $display("FAIL %s: got z=%0b cnt=%0d sat=%0b, want z=%0b cnt=%0d sat=%0b",
                  tag, az, ac, as_, ez, ec, es);
      end
   endtask

   // monitor: compares each queued expectation just after the edge it belongs to
   int    m_sel;
   logic  m_z, m_s, a_z, a_s;
   int    m_c, a_c;
   string m_tag;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_sel.size() != 0) begin
            m_sel = q_sel.pop_front();
            m_z   = q_z.pop_front();
            m_c   = q_cnt.pop_front();
            m_s   = q_sat.pop_front();
            m_tag = q_tag.pop_front();
            if (m_sel == 0) begin
               a_z = bus0.z; a_c = int'(bus0.match_cnt); a_s = bus0.cnt_sat;
            end else begin
               a_z = bus1.z; a_c = int'(bus1.match_cnt); a_s = bus1.cnt_sat;
            end
            n_vec++;
            if (a_z !== m_z || a_c != m_c || a_s !== m_s) begin
               n_err++;
               $display("FAIL %s: got z=%0b cnt=%0d sat=%0b, want z=%0b cnt=%0d sat=%0b",
                        m_tag, a_z, a_c, a_s, m_z, m_c, m_s);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle_all();
      bus0.pattern = 4'b0000; bus0.overlap = 1'b1;
      bus1.pattern = 4'b0000; bus1.overlap = 1'b1;
      e_cnt[0] = 0; e_cnt[1] = 0; e_sat[0] = 1'b0; e_sat[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_now("reset_dut", bus0.z, int'(bus0.match_cnt), bus0.cnt_sat, 1'b0, 0, 1'b0);
      check_now("reset_sat", bus1.z, int'(bus1.match_cnt), bus1.cnt_sat, 1'b0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // overlapping detection on the reference stream
      for (int i = 0; i < 21; i++)
         step(0, s_a[i][0], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, z_ovl[i][0],
              $sformatf("ovl_bit%0d", i + 1));

      // async reset in the middle of a partial 1001
      step(0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_pre1");
      step(0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_pre2");
      step(0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_pre3");
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_now("async_rst", bus0.z, int'(bus0.match_cnt), bus0.cnt_sat, 1'b0, 0, 1'b0);
      #1 rst = 1'b0;
      e_cnt[0] = 0; e_sat[0] = 1'b0; e_cnt[1] = 0; e_sat[1] = 1'b0;
      step(0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_post_lone1");
      step(0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_post_b1");
      step(0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_post_b2");
      step(0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "rst_post_b3");
      step(0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, "rst_post_b4");

      // non-overlapping detection on the same stream
      step(0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, "novl_load");
      for (int i = 0; i < 21; i++)
         step(0, s_a[i][0], 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, z_novl[i][0],
              $sformatf("novl_bit%0d", i + 1));

      // loaded pattern 1101, back-to-back then with idle gaps
      step(0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1, 1'b0, "p1101_load");
      for (int i = 0; i < 7; i++)
         step(0, s_c[i][0], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, z_c[i][0],
              $sformatf("p1101_bit%0d", i + 1));
      step(0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, "gap_load");
      for (int i = 0; i < 7; i++) begin
         step(0, s_c[i][0], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, z_c[i][0],
              $sformatf("gap_bit%0d", i + 1));
         if (i < 6) begin
            step(0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, $sformatf("gap_idle%0da", i + 1));
            step(0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, $sformatf("gap_idle%0db", i + 1));
         end
      end

      // load on the final bit of a match: bit dropped, fill cleared
      step(0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, "ldfin_load1001");
      step(0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "ldfin_b1");
      step(0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "ldfin_b2");
      step(0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "ldfin_b3");
      step(0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, "ldfin_b4_load");
      for (int i = 0; i < 7; i++)
         step(0, s_d[i][0], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, z_d[i][0],
              $sformatf("ldfin_after%0d", i + 1));

      // counter saturation on the 2-bit instance
      for (int i = 0; i < 16; i++)
         step(1, s_e[i][0], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, z_e[i][0],
              $sformatf("sat_bit%0d", i + 1));
      step(1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, "sat_clr");
      step(1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "clrm_b1");
      step(1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "clrm_b2");
      step(1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, "clrm_match_clr");
      step(1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "clrm_b4");
      step(1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "clrm_b5");
      step(1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, "clrm_next_match");

      @(negedge clk);
      idle_all();
      repeat (4) @(posedge clk);
      #2;
      if (q_sel.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", q_sel.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
